// File: rtl/fsm_prog_counter.sv
// Programmable up-counter FSM: counts 0..limit, then reloads or
// stops in DONE; supports pause (hold), abort and handshake release (ack).
module fsm_prog_counter #(
  parameter int WIDTH      = 8,
  parameter bit DONE_PULSE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic             hold,
  input  logic             ack,
  input  logic             reload_en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             tc,
  output logic             busy,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             done_q;
  logic             tc_q;
  logic             busy_q;
  logic             at_term;

  // Terminal count reached for the latched limit.
  assign at_term = (count_q == limit_q);

  // Single FSM register block; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (DONE_PULSE) done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (abort) begin
            count_q <= '0;
          end else if (!hold && go) begin
            state_q <= S_COUNT;
            limit_q <= limit;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_COUNT, S_PAUSE: begin
          if (abort) begin
            state_q <= S_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
          end else if (hold) begin
            state_q <= S_PAUSE;
          end else if (at_term) begin
            tc_q <= 1'b1;
            if (reload_en) begin
              state_q <= S_COUNT;
              count_q <= '0;
            end else begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= S_COUNT;
            count_q <= count_q + ONE;
          end
        end
        S_DONE: begin
          if (abort) begin
            state_q <= S_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
          end else if (hold) begin
            state_q <= S_DONE;
          end else if (go) begin
            state_q <= S_COUNT;
            limit_q <= limit;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else if (ack) begin
            state_q <= S_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign count   = count_q;
  assign done    = done_q;
  assign tc      = tc_q;
  assign busy    = busy_q;
  assign state_o = state_q;

endmodule

// File: doc/fsm_prog_counter.md
FSM_PROG_COUNTER -- requirements
Module: fsm_prog_counter

Interface
REQ-001 Parameter: WIDTH, default 8, width of count and limit (legal range 2..32).
REQ-002 Parameter: DONE_PULSE, default 0; 0 = done is a level for the whole DONE state, 1 = done is a 1-cycle pulse on DONE entry.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: go  input  1  start request.
REQ-006 Port: abort  input  1  cancel; returns the block to IDLE.
REQ-007 Port: hold  input  1  pause request while counting.
REQ-008 Port: ack  input  1  releases DONE back to IDLE.
REQ-009 Port: reload_en  input  1  auto-reload mode select, sampled at terminal count.
REQ-010 Port: limit  input  WIDTH  terminal count value, latched on start.
REQ-011 Port: count  output  WIDTH  registered current count.
REQ-012 Port: done  output  1  completion flag, registered.
REQ-013 Port: tc  output  1  registered terminal-count pulse.
REQ-014 Port: busy  output  1  high in COUNT or PAUSE.
REQ-015 Port: state_o  output  2  current state: IDLE=0, COUNT=1, PAUSE=2, DONE=3.

Function
REQ-016 All outputs SHALL be registered; all transitions SHALL occur on rising clk.
REQ-017 Event priority in every state SHALL be: rst > abort > hold > terminal/go/ack.
REQ-018 IDLE, go=1: next state COUNT, limit_q<=limit, count<=0; otherwise remain in IDLE with count=0.
REQ-019 COUNT, no abort/hold, count!=limit_q: count<=count+1; state stays COUNT.
REQ-020 COUNT, count==limit_q, reload_en=1: count<=0, stay in COUNT, tc pulses high for the following cycle.
REQ-021 COUNT, count==limit_q, reload_en=0: state<=DONE, count holds at limit_q, tc pulses high for the following cycle.
REQ-022 COUNT SHALL last exactly limit_q+1 cycles per pass; limit=0 gives one COUNT cycle.
REQ-023 COUNT, hold=1: state<=PAUSE, count frozen; the terminal check is suppressed that cycle.
REQ-024 PAUSE: count frozen; hold=0 returns to COUNT and counting resumes from the frozen value.
REQ-025 COUNT or PAUSE, abort=1: state<=IDLE, count<=0, no tc, no done.
REQ-026 go in COUNT or PAUSE SHALL be ignored; limit changes SHALL have no effect until the next start.
REQ-027 DONE, go=1: restart as in REQ-018, with go taking priority over ack.
REQ-028 DONE, ack=1 and go=0: state<=IDLE, count<=0.
REQ-029 DONE, abort=1: state<=IDLE.
REQ-030 DONE_PULSE=0: done=1 exactly while state_o==DONE.
REQ-031 DONE_PULSE=1: done=1 only in the first cycle after DONE entry.
REQ-032 count SHALL never exceed limit_q and SHALL never wrap past 2^WIDTH-1.

Reset
REQ-033 With rst=1 at a clock edge: state=IDLE, count=0, limit_q=0, done=0, tc=0, busy=0.
REQ-034 rst SHALL take effect from any state, including mid-count, PAUSE and DONE.
REQ-035 Inputs SHALL be ignored while rst=1.

Verification
REQ-036 limit=3, reload_en=0, go pulse at edge 0 -> count 0,1,2,3 on edges 0..3; DONE, tc=1 and done=1 after edge 4; busy=0 after edge 4.
REQ-037 limit=2, reload_en=1 -> count 0,1,2,0,1,2...; tc high every 3rd cycle; never DONE. Then drop reload_en -> DONE at the next terminal count.
REQ-038 limit=5, hold held for 3 cycles at count=2 -> state_o=2 and count stays at 2 for 3 cycles; DONE entered 3 cycles later than the unpaused run.
REQ-039 abort at count=4 with limit=9 -> IDLE and count=0 next cycle; tc and done never assert.
REQ-040 DONE_PULSE=1 -> done high for exactly 1 cycle. In DONE, go and ack together -> restart to COUNT with count=0.
REQ-041 rst asserted mid-COUNT with limit=255 -> all outputs at reset values next cycle. limit=0 -> a single COUNT cycle, then DONE.
